// File: rtl/led_fader.sv
// led_fader: per-channel brightness that saturates while the input bit is set,
// decays in fixed steps after it clears, and drives each LED pin through a shared PWM counter.
// Optional gamma curve: define LED_FADER_GAMMA_EN (default build is linear).
module led_fader #(
  parameter int CLK_FREQ     = 25_000_000,
  parameter int DECAY_HZ     = 1000,
  parameter int PWM_BITS     = 8,
  parameter int DECAY_AMOUNT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] leds_in,
  output logic [7:0] leds_out,
  output logic       active
);

  localparam int TICK_DIV = CLK_FREQ / DECAY_HZ;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [TW-1:0]       TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0]       TICK_ONE  = TW'(1);
  localparam logic [PWM_BITS-1:0] PWM_ONE   = PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] LVL_MAX   = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] DEC_STEP  = PWM_BITS'(DECAY_AMOUNT);

  logic [7:0]                in_q, in_d;
  logic [TW-1:0]             tick_cnt_q, tick_cnt_d;
  logic [PWM_BITS-1:0]       pwm_cnt_q, pwm_cnt_d;
  logic [7:0][PWM_BITS-1:0]  level_q, level_d;
  logic [7:0][PWM_BITS-1:0]  eff;
  logic [7:0]                leds_out_q, leds_out_d;
  logic                      active_q, active_d;
  logic                      decay_tick;

  // Shared tick divider and free-running PWM counter.
  always_comb begin
    decay_tick = (tick_cnt_q == TICK_LAST);
    in_d       = leds_in;
    pwm_cnt_d  = pwm_cnt_q + PWM_ONE;
    if (decay_tick) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + TICK_ONE;
    end
  end

  // Per-channel level: set beats decay, decay saturates at zero.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < 8; i++) begin
      if (in_q[i]) begin
        level_d[i] = LVL_MAX;
      end else if (decay_tick) begin
        if (level_q[i] > DEC_STEP) begin
          level_d[i] = level_q[i] - DEC_STEP;
        end else begin
          level_d[i] = '0;
        end
      end else begin
        level_d[i] = level_q[i];
      end
    end
  end

`ifdef LED_FADER_GAMMA_EN
  logic [7:0][2*PWM_BITS-1:0] sq;

  // Square-law curve: keep the upper half of level*level.
  always_comb begin
    sq  = '0;
    eff = '0;
    for (int i = 0; i < 8; i++) begin
      sq[i]  = {{PWM_BITS{1'b0}}, level_q[i]} * {{PWM_BITS{1'b0}}, level_q[i]};
      eff[i] = sq[i][2*PWM_BITS-1:PWM_BITS];
    end
  end
`else
  // Linear brightness.
  always_comb begin
    eff = level_q;
  end
`endif

  // PWM compare and activity flag.
  always_comb begin
    leds_out_d = '0;
    for (int i = 0; i < 8; i++) begin
      leds_out_d[i] = (eff[i] > pwm_cnt_q);
    end
    active_d = |level_q;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q       <= 8'h00;
      tick_cnt_q <= '0;
      pwm_cnt_q  <= '0;
      level_q    <= '0;
      leds_out_q <= 8'h00;
      active_q   <= 1'b0;
    end else begin
      in_q       <= in_d;
      tick_cnt_q <= tick_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      level_q    <= level_d;
      leds_out_q <= leds_out_d;
      active_q   <= active_d;
    end
  end

  assign leds_out = leds_out_q;
  assign active   = active_q;

endmodule

// File: tb/tb_led_fader.sv
// Self-checking bench for led_fader (TICK_DIV = 10, MAX = 15, step 4) using a cycle
// scoreboard of expected {leds_out, active} plus directed level/tick checks.
module tb_led_fader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] leds_in;
  logic [7:0] leds_out;
  logic       active;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] exp_q[$];
  int         b_lvl[8];
  logic [7:0] b_in;
  int         n;
  bit         last_tick;
  int         ones;
  int         fade_exp[4] = '{11, 7, 3, 0};

  led_fader #(
    .CLK_FREQ(1000),
    .DECAY_HZ(100),
    .PWM_BITS(4),
    .DECAY_AMOUNT(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .leds_in(leds_in),
    .leds_out(leds_out),
    .active(active)
  );

  always #5 clk = ~clk;

  function automatic int bench_eff(int lvl);
`ifdef LED_FADER_GAMMA_EN
    return (lvl * lvl) / 16;
`else
    return lvl;
`endif
  endfunction

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) b_lvl[i] = 0;
    b_in      = 8'h00;
    n         = 0;
    last_tick = 1'b0;
    exp_q.delete();
  endtask

  // One clock: predict the output of the coming edge, advance the model, compare.
  task automatic step();
    logic [7:0] eo;
    logic       ea;
    logic [8:0] e;
    eo = 8'h00;
    ea = 1'b0;
    for (int i = 0; i < 8; i++) begin
      eo[i] = (bench_eff(b_lvl[i]) > (n % 16));
      if (b_lvl[i] != 0) ea = 1'b1;
    end
    exp_q.push_back({eo, ea});
    last_tick = ((n % 10) == 9);
    for (int i = 0; i < 8; i++) begin
      if (b_in[i]) b_lvl[i] = 15;
      else if (last_tick) b_lvl[i] = (b_lvl[i] > 4) ? b_lvl[i] - 4 : 0;
    end
    b_in = leds_in;
    n++;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("sb_out", 32'({leds_out, active}), 32'(e));
  endtask

  task automatic run_until_tick();
    for (int k = 0; k < 20; k++) begin
      step();
      if (last_tick) return;
    end
    check_eq("tick_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    rst_n   = 1'b0;
    leds_in = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_leds", 32'(leds_out), 32'(0));
    check_eq("rst_active", 32'(active), 32'(0));
    check_eq("rst_level", 32'(dut.level_q), 32'(0));
    rst_n = 1'b1;

    repeat (50) step();

    leds_in = 8'h01;
    repeat (40) step();
    ones = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      ones += int'(leds_out[0]);
      check_eq("upper_bits", 32'(leds_out[7:1]), 32'(0));
      check_eq("active_on", 32'(active), 32'(1));
    end
`ifdef LED_FADER_GAMMA_EN
    check_eq("duty_full", 32'(ones), 32'(14));
`else
    check_eq("duty_full", 32'(ones), 32'(15));
`endif

    leds_in = 8'h00;
    step();
    for (int k = 0; k < 4; k++) begin
      run_until_tick();
      check_eq("fade_lvl0", 32'(dut.level_q[0]), 32'(fade_exp[k]));
    end
    check_eq("active_lag", 32'(active), 32'(1));
    step();
    check_eq("active_fall", 32'(active), 32'(0));
    repeat (16) step();

    leds_in = 8'h08;
    repeat (3) step();
    leds_in = 8'h00;
    step();
    run_until_tick();
    run_until_tick();
    check_eq("lvl3_seven", 32'(dut.level_q[3]), 32'(7));
    for (int k = 0; k < 20 && (n % 10) != 8; k++) step();
    leds_in = 8'h08;
    step();
    leds_in = 8'h00;
    check_eq("tick_at_set", 32'(dut.decay_tick), 32'(1));
    step();
    check_eq("set_beats_decay", 32'(dut.level_q[3]), 32'(15));
    step();
    for (int k = 0; k < 4; k++) begin
      run_until_tick();
      check_eq("fade_lvl3", 32'(dut.level_q[3]), 32'(fade_exp[k]));
    end

    leds_in = 8'h01;
    repeat (3) step();
    leds_in = 8'h00;
    step();
    run_until_tick();
    run_until_tick();
    check_eq("midfade_lvl", 32'(dut.level_q[0]), 32'(7));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_leds", 32'(leds_out), 32'(0));
    check_eq("async_active", 32'(active), 32'(0));
    check_eq("async_level", 32'(dut.level_q), 32'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) step();
    check_eq("no_tick_c8", 32'(dut.decay_tick), 32'(0));
    step();
    check_eq("first_tick_c9", 32'(dut.decay_tick), 32'(1));
    repeat (12) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
